// File: rtl/instr_feeder_if.sv
// Loader and core-side bus of the instruction feeder.
// The feeder takes the slave view; loader/core models take the master view.
interface instr_feeder_if;
    logic        Wr_en;
    logic [15:0] Wr_data;
    logic        Full;
    logic        Empty;
    logic        Drop;
    logic [15:0] DIN;
    logic        Run;
    logic        Done;

    modport slave (
        input  Wr_en,
        input  Wr_data,
        input  Done,
        output Full,
        output Empty,
        output Drop,
        output DIN,
        output Run
    );

    modport master (
        output Wr_en,
        output Wr_data,
        output Done,
        input  Full,
        input  Empty,
        input  Drop,
        input  DIN,
        input  Run
    );
endinterface

// File: rtl/instr_feeder.sv
// Instruction-issue front end: FIFO of 16-bit words, one Run
// pulse per word, next word only after the core reports Done.
module instr_feeder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Enable,
    instr_feeder_if.slave      bus,
    output logic               Busy,
    output logic [7:0]         Retired
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           drop_q, drop_d;
    logic [7:0]     ret_q, ret_d;

    logic full;
    logic empty;
    logic wr_acc;
    logic pop;

    assign full   = (cnt_q == (AW+1)'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign wr_acc = bus.Wr_en && !full;
    assign pop    = (state_q == ISSUE);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        drop_d   = drop_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (bus.Wr_en && full) begin
            drop_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_acc, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        unique case (state_q)
            IDLE: begin
                if (Enable && !empty) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.Done) begin
                    ret_d   = ret_q + 8'd1;
                    state_d = (Enable && !empty) ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
            ret_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
            ret_q    <= ret_d;
        end
    end

    // Storage is not reset; pointers and count alone define validity.
    always_ff @(posedge Clock) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.Wr_data;
        end
    end

    assign bus.Full  = full;
    assign bus.Empty = empty;
    assign bus.Drop  = drop_q;
    assign bus.Run   = (state_q == ISSUE);
    assign bus.DIN   = (state_q == ISSUE) ? mem_q[rd_ptr_q] : 16'h0000;
    assign Busy      = (state_q == ISSUE) || (state_q == WAIT);
    assign Retired   = ret_q;
endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder with a small multicycle core model
// (mv/mvt take 2 cycles, add/sub take 4, Done in the last step).
module tb_instr_feeder;
    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Enable;
    logic       Busy;
    logic [7:0] Retired;

    instr_feeder_if bus();

    instr_feeder #(.DEPTH(8), .AW(3)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Enable  (Enable),
        .bus     (bus),
        .Busy    (Busy),
        .Retired (Retired)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;
    logic prev_run = 1'b0;

    // Core model
    logic [2:0]  step;
    logic [2:0]  len;
    logic [15:0] ir;
    logic [15:0] r [8];
    logic        model_done;
    logic        done_inj;

    assign model_done = (step != 3'd0) && (step == len - 3'd1);
    assign bus.Done   = model_done | done_inj;

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step <= 3'd0;
            len  <= 3'd2;
        end else if (bus.Run) begin
            step <= 3'd1;
            len  <= (bus.DIN[15:13] >= 3'd2) ? 3'd4 : 3'd2;
            ir   <= bus.DIN;
        end else if (step != 3'd0) begin
            if (step == len - 3'd1) begin
                step <= 3'd0;
                if (ir[15:13] == 3'd0) begin
                    r[ir[11:9]] <= {7'd0, ir[8:0]};
                end else if (ir[15:13] == 3'd2) begin
                    r[ir[11:9]] <= r[ir[11:9]] + r[ir[2:0]];
                end
            end else begin
                step <= step + 3'd1;
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
        if (bus.Run) begin
            checks++;
            if (prev_run) begin
                failures++;
                $display("FAIL run_twice Run=1 in consecutive cycles, required single pulse");
            end
        end
        prev_run = bus.Run;
    endtask

    task automatic wr(input logic [15:0] w);
        bus.Wr_en   = 1'b1;
        bus.Wr_data = w;
        tick();
        bus.Wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        tick();
        tick();
        Resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        Enable      = 1'b0;
        bus.Wr_en   = 1'b0;
        bus.Wr_data = 16'h0;
        done_inj    = 1'b0;
        do_reset();
        checks++;
        if ({bus.Full, bus.Empty, bus.Drop, bus.Run, Busy} !== 5'b01000) begin
            failures++;
            $display("FAIL reset_flags got F/E/D/R/B=%b required 01000",
                     {bus.Full, bus.Empty, bus.Drop, bus.Run, Busy});
        end
        checks++;
        if (bus.DIN !== 16'h0 || Retired !== 8'd0) begin
            failures++;
            $display("FAIL reset_vals got DIN=%h Retired=%0d required 0000/0",
                     bus.DIN, Retired);
        end
    endtask

    task automatic test_single();
        wr(16'h1005);
        tick();
        checks++;
        if (bus.Empty !== 1'b0 || bus.Run !== 1'b0) begin
            failures++;
            $display("FAIL single_queued got Empty=%b Run=%b required 0/0",
                     bus.Empty, bus.Run);
        end
        Enable = 1'b1;
        tick();
        checks++;
        if (bus.Run !== 1'b1 || bus.DIN !== 16'h1005) begin
            failures++;
            $display("FAIL single_issue got Run=%b DIN=%h required 1/1005",
                     bus.Run, bus.DIN);
        end
        tick();
        checks++;
        if (bus.Run !== 1'b0 || bus.Done !== 1'b1 || Busy !== 1'b1) begin
            failures++;
            $display("FAIL single_wait got Run=%b Done=%b Busy=%b required 0/1/1",
                     bus.Run, bus.Done, Busy);
        end
        tick();
        checks++;
        if (Retired !== 8'd1 || bus.Empty !== 1'b1 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL single_retire got Ret=%0d Empty=%b Busy=%b required 1/1/0",
                     Retired, bus.Empty, Busy);
        end
        Enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] prog [3];
        logic [9:0]  runs;
        int k;
        prog[0] = 16'h1005;
        prog[1] = 16'h1203;
        prog[2] = 16'h4001;
        for (int i = 0; i < 3; i++) wr(prog[i]);
        Enable = 1'b1;
        runs   = '0;
        k      = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            runs[c] = bus.Run;
            if (bus.Run) begin
                checks++;
                if (k > 2 || bus.DIN !== prog[k]) begin
                    failures++;
                    $display("FAIL b2b_din cycle %0d got %h", c, bus.DIN);
                end
                k++;
            end
            if (c == 8) begin
                checks++;
                if (Retired !== 8'd4) begin
                    failures++;
                    $display("FAIL b2b_retired got %0d required 4", Retired);
                end
            end
        end
        checks++;
        if (runs !== 10'b00_0001_0101) begin
            failures++;
            $display("FAIL b2b_pattern got %b required 0000010101", runs);
        end
        checks++;
        if (r[0] !== 16'd8) begin
            failures++;
            $display("FAIL b2b_r0 got %0d required 8", r[0]);
        end
        Enable = 1'b0;
    endtask

    task automatic test_full();
        int n;
        int bound;
        for (int i = 0; i < 8; i++) wr(16'h1400 | 16'(i));
        checks++;
        if (bus.Full !== 1'b1 || bus.Drop !== 1'b0) begin
            failures++;
            $display("FAIL full_after8 got Full=%b Drop=%b required 1/0",
                     bus.Full, bus.Drop);
        end
        wr(16'h14FF);
        checks++;
        if (bus.Full !== 1'b1 || bus.Drop !== 1'b1) begin
            failures++;
            $display("FAIL full_drop got Full=%b Drop=%b required 1/1",
                     bus.Full, bus.Drop);
        end
        Enable = 1'b1;
        n      = 0;
        bound  = 0;
        tick();
        while (!(bus.Empty && !Busy) && bound < 200) begin
            if (bus.Run) begin
                checks++;
                if (bus.DIN !== (16'h1400 | 16'(n))) begin
                    failures++;
                    $display("FAIL full_order issue %0d got %h required %h",
                             n, bus.DIN, 16'h1400 | 16'(n));
                end
                n++;
            end
            tick();
            bound++;
        end
        checks++;
        if (n != 8 || Retired !== 8'd12) begin
            failures++;
            $display("FAIL full_drain got issues=%0d Ret=%0d required 8/12",
                     n, Retired);
        end
        Enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        wr(16'h4001);
        wr(16'h1005);
        wr(16'h1203);
        Enable = 1'b1;
        tick();
        Enable = 1'b0;
        checks++;
        if (bus.Run !== 1'b1 || bus.DIN !== 16'h4001) begin
            failures++;
            $display("FAIL endrop_issue got Run=%b DIN=%h required 1/4001",
                     bus.Run, bus.DIN);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (Busy !== 1'b1) begin
            failures++;
            $display("FAIL endrop_inflight got Busy=%b required 1", Busy);
        end
        tick();
        checks++;
        if (Retired !== 8'd13 || Busy !== 1'b0 || bus.Empty !== 1'b0) begin
            failures++;
            $display("FAIL endrop_idle got Ret=%0d Busy=%b Empty=%b required 13/0/0",
                     Retired, Busy, bus.Empty);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.Run !== 1'b0 || Retired !== 8'd13) begin
            failures++;
            $display("FAIL endrop_hold got Run=%b Ret=%0d required 0/13",
                     bus.Run, Retired);
        end
    endtask

    task automatic test_async_reset();
        Enable = 1'b1;
        tick();
        tick();
        #2;
        Resetn = 1'b0;
        #1;
        checks++;
        if ({bus.Full, bus.Empty, bus.Drop, bus.Run, Busy} !== 5'b01000 ||
            bus.DIN !== 16'h0 || Retired !== 8'd0) begin
            failures++;
            $display("FAIL async_reset got FEDRB=%b DIN=%h Ret=%0d required 01000/0000/0",
                     {bus.Full, bus.Empty, bus.Drop, bus.Run, Busy}, bus.DIN, Retired);
        end
        Enable = 1'b0;
        tick();
        Resetn = 1'b1;
        tick();
        wr(16'h1203);
        Enable = 1'b1;
        tick();
        checks++;
        if (bus.Run !== 1'b1 || bus.DIN !== 16'h1203) begin
            failures++;
            $display("FAIL async_resume got Run=%b DIN=%h required 1/1203",
                     bus.Run, bus.DIN);
        end
        tick();
        tick();
        checks++;
        if (Retired !== 8'd1 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL async_retire got Ret=%0d Busy=%b required 1/0",
                     Retired, Busy);
        end
        Enable = 1'b0;
    endtask

    task automatic test_wrap();
        int w;
        int issued;
        int bound;
        do_reset();
        Enable = 1'b1;
        w      = 0;
        issued = 0;
        bound  = 0;
        while ((issued < 257 || Busy) && bound < 2000) begin
            bus.Wr_en   = (w < 257) && !bus.Full;
            bus.Wr_data = 16'h1000 | 16'(w[7:0]);
            if (bus.Wr_en) w++;
            tick();
            if (bus.Run) issued++;
            bound++;
        end
        bus.Wr_en = 1'b0;
        checks++;
        if (issued != 257 || Retired !== 8'h01 || bus.Drop !== 1'b0) begin
            failures++;
            $display("FAIL wrap got issued=%0d Ret=%h Drop=%b required 257/01/0",
                     issued, Retired, bus.Drop);
        end
        Enable   = 1'b0;
        done_inj = 1'b1;
        tick();
        tick();
        done_inj = 1'b0;
        checks++;
        if (Retired !== 8'h01) begin
            failures++;
            $display("FAIL done_idle got Ret=%h required 01", Retired);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_enable_drop();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
